// File: rtl/rcb_contact_debounce.sv
// Dual-contact (NC/NO) switch conditioner: 2-flop sync, tick-based debounce, per-channel REL/PRS/FAULT state machine.
// Latency: DEB_TICKS*TICK_DIV .. (DEB_TICKS+1)*TICK_DIV+3 clocks from a raw contact edge to pressed/event.
// Backpressure: none; outputs are level/pulse status, consumers sample every clock.
//
// Ports:
//   clk_100m     system clock
//   rst_syn      synchronous reset, active-high
//   nc_in/no_in  raw asynchronous NC/NO contacts, one bit per channel
//   fault_clr    per-channel one-clock fault clear request
//   pressed      debounced contact state (1 = NC=0/NO=1)
//   press_evt    one-clock pulse on released->pressed
//   release_evt  one-clock pulse on pressed->released
//   fault        sticky illegal-pair flag
module rcb_contact_debounce #(
    parameter int N_CH        = 8,
    parameter int TICK_DIV    = 100,
    parameter int DEB_TICKS   = 5000,
    parameter int FAULT_TICKS = 20000,
    parameter int CNT_W       = 16
) (
    input  logic            clk_100m,
    input  logic            rst_syn,
    input  logic [N_CH-1:0] nc_in,
    input  logic [N_CH-1:0] no_in,
    input  logic [N_CH-1:0] fault_clr,
    output logic [N_CH-1:0] pressed,
    output logic [N_CH-1:0] press_evt,
    output logic [N_CH-1:0] release_evt,
    output logic [N_CH-1:0] fault
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] CODE_REL = 2'b10;
    localparam logic [1:0] CODE_PRS = 2'b01;

    localparam logic [CNT_W-1:0] DEB_CNT   = CNT_W'(DEB_TICKS);
    localparam logic [CNT_W-1:0] FAULT_CNT = CNT_W'(FAULT_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [PW-1:0]    PRESC_TOP = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_REL = 2'd0,
        ST_PRS = 2'd1,
        ST_FLT = 2'd2
    } state_t;

    // Synchroniser stages. Preset to the released code so reset can never
    // present an illegal pair to the candidate logic.
    logic [N_CH-1:0] nc_s1, nc_s2;
    logic [N_CH-1:0] no_s1, no_s2;

    logic [PW-1:0]    presc_q;
    logic             tick;

    logic [1:0]       cand_q  [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    state_t           state_q [N_CH];
    state_t           state_d [N_CH];

    logic [N_CH-1:0]  press_d;
    logic [N_CH-1:0]  release_d;

    assign tick = (presc_q == PRESC_TOP);

    // Synchroniser, shared prescaler, candidate/stability tracking.
    always_ff @(posedge clk_100m) begin
        if (rst_syn) begin
            nc_s1   <= '1;
            nc_s2   <= '1;
            no_s1   <= '0;
            no_s2   <= '0;
            presc_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cand_q[i] <= CODE_REL;
                cnt_q[i]  <= '0;
            end
        end else begin
            nc_s1   <= nc_in;
            nc_s2   <= nc_s1;
            no_s1   <= no_in;
            no_s2   <= no_s1;
            presc_q <= tick ? '0 : presc_q + PW'(1);
            for (int i = 0; i < N_CH; i++) begin
                // A code change restarts the stability window even on a tick.
                if ({nc_s2[i], no_s2[i]} != cand_q[i]) begin
                    cand_q[i] <= {nc_s2[i], no_s2[i]};
                    cnt_q[i]  <= '0;
                end else if (tick && (cnt_q[i] != CNT_MAX)) begin
                    cnt_q[i]  <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Per-channel state register and registered event pulses.
    always_ff @(posedge clk_100m) begin
        if (rst_syn) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_REL;
            end
            press_evt   <= '0;
            release_evt <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
            end
            press_evt   <= press_d;
            release_evt <= release_d;
        end
    end

    // Next-state decode. The illegal-code check comes first so a stable bad
    // pair wins from any state; leaving PRESSED this way raises no event.
    always_comb begin
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            if (((cand_q[i] == 2'b00) || (cand_q[i] == 2'b11)) && (cnt_q[i] >= FAULT_CNT)) begin
                state_d[i] = ST_FLT;
            end else begin
                case (state_q[i])
                    ST_REL: begin
                        if ((cand_q[i] == CODE_PRS) && (cnt_q[i] >= DEB_CNT)) begin
                            state_d[i] = ST_PRS;
                            press_d[i] = 1'b1;
                        end
                    end
                    ST_PRS: begin
                        if ((cand_q[i] == CODE_REL) && (cnt_q[i] >= DEB_CNT)) begin
                            state_d[i]   = ST_REL;
                            release_d[i] = 1'b1;
                        end
                    end
                    ST_FLT: begin
                        // Clear only lands on a settled legal code; otherwise it is dropped.
                        if (fault_clr[i] && (cnt_q[i] >= DEB_CNT)) begin
                            if (cand_q[i] == CODE_REL) begin
                                state_d[i] = ST_REL;
                            end else if (cand_q[i] == CODE_PRS) begin
                                state_d[i] = ST_PRS;
                            end
                        end
                    end
                    default: begin
                        state_d[i] = ST_REL;
                    end
                endcase
            end
        end
    end

    always_comb begin
        pressed = '0;
        fault   = '0;
        for (int i = 0; i < N_CH; i++) begin
            pressed[i] = (state_q[i] == ST_PRS);
            fault[i]   = (state_q[i] == ST_FLT);
        end
    end

endmodule

// File: tb/tb_rcb_contact_debounce.sv
module tb_rcb_contact_debounce;

    localparam int N_CH = 8;

    logic            clk_100m = 1'b0;
    logic            rst_syn;
    logic [N_CH-1:0] nc_in;
    logic [N_CH-1:0] no_in;
    logic [N_CH-1:0] fault_clr;
    logic [N_CH-1:0] pressed;
    logic [N_CH-1:0] press_evt;
    logic [N_CH-1:0] release_evt;
    logic [N_CH-1:0] fault;

    int vectors = 0;
    int miscompares = 0;

    int pcnt [N_CH];
    int rcnt [N_CH];
    int wide_err = 0;
    logic [N_CH-1:0] prev_p = '0;
    logic [N_CH-1:0] prev_r = '0;

    always #5 clk_100m = ~clk_100m;

    rcb_contact_debounce #(
        .N_CH       (N_CH),
        .TICK_DIV   (4),
        .DEB_TICKS  (3),
        .FAULT_TICKS(8),
        .CNT_W      (16)
    ) dut (
        .clk_100m   (clk_100m),
        .rst_syn    (rst_syn),
        .nc_in      (nc_in),
        .no_in      (no_in),
        .fault_clr  (fault_clr),
        .pressed    (pressed),
        .press_evt  (press_evt),
        .release_evt(release_evt),
        .fault      (fault)
    );

    // Event counter: values are sampled before the edge updates them, so each
    // one-clock pulse is counted exactly once; back-to-back highs are flagged.
    initial begin
        for (int i = 0; i < N_CH; i++) begin
            pcnt[i] = 0;
            rcnt[i] = 0;
        end
    end

    always @(posedge clk_100m) begin
        for (int i = 0; i < N_CH; i++) begin
            if (press_evt[i] === 1'b1) begin
                pcnt[i] = pcnt[i] + 1;
                if (prev_p[i] === 1'b1) wide_err = wide_err + 1;
            end
            if (release_evt[i] === 1'b1) begin
                rcnt[i] = rcnt[i] + 1;
                if (prev_r[i] === 1'b1) wide_err = wide_err + 1;
            end
        end
        prev_p = press_evt;
        prev_r = release_evt;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_100m);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert ((obs >= lo) && (obs <= hi)) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic set_ch(input int ch, input logic nc, input logic no);
        nc_in[ch] = nc;
        no_in[ch] = no;
    endtask

    // Returns the number of clocks until the selected output reads 1, or -1.
    task automatic wait_rise(input int ch, input bit sel_fault, input int max_cyc, output int n);
        n = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk_100m);
            if ((sel_fault ? fault[ch] : pressed[ch]) === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int snap_p;
        int snap_r;

        rst_syn   = 1'b1;
        nc_in     = '1;
        no_in     = '0;
        fault_clr = '0;
        step(3);

        // Reset state
        check("rst_pressed", 32'(pressed), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_press_evt", 32'(press_evt), 32'h0);
        check("rst_release_evt", 32'(release_evt), 32'h0);

        // Released code held after reset: nothing happens
        rst_syn = 1'b0;
        step(200);
        check("idle_pressed", 32'(pressed), 32'h0);
        check("idle_fault", 32'(fault), 32'h0);
        check("idle_press_cnt", 32'(pcnt[0] + pcnt[1] + pcnt[7]), 32'h0);
        check("idle_release_cnt", 32'(rcnt[0] + rcnt[1] + rcnt[7]), 32'h0);

        // ch0 press: latency window and single-cycle aligned event
        set_ch(0, 1'b0, 1'b1);
        wait_rise(0, 1'b0, 25, n);
        check_range("ch0_latency", n, 12, 19);
        check("ch0_evt_at_rise", 32'(press_evt[0]), 32'h1);
        check("ch0_others_idle", 32'(pressed[7:1]), 32'h0);
        step(1);
        check("ch0_evt_one_clk", 32'(press_evt[0]), 32'h0);
        step(2);
        check("ch0_press_cnt", 32'(pcnt[0]), 32'h1);

        // ch1 press, 8-clk release glitch is filtered
        set_ch(1, 1'b0, 1'b1);
        step(25);
        check("ch1_pressed", 32'(pressed[1]), 32'h1);
        set_ch(1, 1'b1, 1'b0);
        step(8);
        set_ch(1, 1'b0, 1'b1);
        step(40);
        check("ch1_glitch_pressed", 32'(pressed[1]), 32'h1);
        check("ch1_glitch_no_rel", 32'(rcnt[1]), 32'h0);

        // ch1 20-clk release is accepted once, then re-pressed
        set_ch(1, 1'b1, 1'b0);
        step(20);
        set_ch(1, 1'b0, 1'b1);
        step(40);
        check("ch1_rel_once", 32'(rcnt[1]), 32'h1);
        check("ch1_repressed", 32'(pressed[1]), 32'h1);
        check("ch1_press_cnt", 32'(pcnt[1]), 32'h2);

        // ch2 illegal 11 -> fault
        set_ch(2, 1'b1, 1'b1);
        wait_rise(2, 1'b1, 45, n);
        check_range("ch2_fault_latency", n, 32, 39);
        check("ch2_fault_not_pressed", 32'(pressed[2]), 32'h0);
        step((n > 0 && n < 40) ? 40 - n : 1);
        fault_clr[2] = 1'b1;
        step(1);
        fault_clr[2] = 1'b0;
        step(5);
        check("ch2_clr_while_bad", 32'(fault[2]), 32'h1);
        set_ch(2, 1'b1, 1'b0);
        step(20);
        check("ch2_still_fault", 32'(fault[2]), 32'h1);
        fault_clr[2] = 1'b1;
        step(1);
        fault_clr[2] = 1'b0;
        check("ch2_cleared", 32'(fault[2]), 32'h0);
        check("ch2_cleared_released", 32'(pressed[2]), 32'h0);
        step(3);
        check("ch2_no_events", 32'(pcnt[2] + rcnt[2]), 32'h0);

        // ch3 reset mid-debounce (cnt=2 after 11 clks)
        set_ch(3, 1'b0, 1'b1);
        step(11);
        rst_syn = 1'b1;
        step(2);
        rst_syn = 1'b0;
        check("rst3_pressed", 32'(pressed), 32'h0);
        check("rst3_fault", 32'(fault), 32'h0);
        check("rst3_evts", 32'({press_evt, release_evt}), 32'h0);
        wait_rise(3, 1'b0, 25, n);
        check_range("ch3_latency_after_rst", n, 12, 19);

        // ch4 pressed, short 00 excursion does not fault nor pulse
        set_ch(4, 1'b0, 1'b1);
        step(25);
        check("ch4_pressed", 32'(pressed[4]), 32'h1);
        snap_p = pcnt[4];
        snap_r = rcnt[4];
        set_ch(4, 1'b0, 1'b0);
        step(24);
        set_ch(4, 1'b0, 1'b1);
        step(40);
        check("ch4_no_fault", 32'(fault[4]), 32'h0);
        check("ch4_still_pressed", 32'(pressed[4]), 32'h1);
        check("ch4_no_press_evt", 32'(pcnt[4]), 32'(snap_p));
        check("ch4_no_release_evt", 32'(rcnt[4]), 32'(snap_r));

        check("evt_width", 32'(wide_err), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
